bp_be_scoreboard: RTL and testbench

- Backend register scoreboard that sequences dispatch of long-latency instructions: multiply/divide, FP and memory ops whose writeback is not covered by the pipelined-stage comparison in the checker.
- Tracks outstanding writes per integer and FP architectural register.
- Gates the issue handshake on RAW and WAW hazards.
- Runs a drain sequence after a flush/roll.
- Sits beside the hazard detector; its issue_ready_o is ANDed into dispatch validity upstream of the issue stage.

---
 rtl/bp_be_scoreboard_pkg.sv | 36 +++
 rtl/bp_be_scoreboard_if.sv | 38 +++
 rtl/bp_be_scoreboard_bank.sv | 98 +++++++++
 rtl/bp_be_scoreboard.sv | 99 +++++++++
 tb/tb_bp_be_scoreboard.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_scoreboard_pkg.sv
// Shared types for the backend register scoreboard.
//   sb_reg_addr_width_gp : architectural register index width
//   bp_be_sb_state_e     : scoreboard FSM states (run / drain)
//   bp_be_sb_issue_s     : issue-side fields of one dispatch
//   bp_be_sb_wb_s        : one long-latency writeback
package bp_be_scoreboard_pkg;

    localparam int unsigned sb_reg_addr_width_gp = 5;

    typedef logic [sb_reg_addr_width_gp-1:0] sb_reg_addr_t;

    typedef enum logic {
        e_sb_run,
        e_sb_drain
    } bp_be_sb_state_e;

    typedef struct packed {
        logic         v;
        logic         irs1_v;
        logic         irs2_v;
        logic         frs1_v;
        logic         frs2_v;
        sb_reg_addr_t rs1_addr;
        sb_reg_addr_t rs2_addr;
        logic         iwb_v;
        logic         fwb_v;
        sb_reg_addr_t rd_addr;
    } bp_be_sb_issue_s;

    typedef struct packed {
        logic         v;
        logic         fp;
        sb_reg_addr_t rd_addr;
    } bp_be_sb_wb_s;

endpackage

// File: rtl/bp_be_scoreboard_if.sv
// Issue / writeback bundle between dispatch and the scoreboard.
// Signal suffixes are from the scoreboard's point of view.
//   slave  : scoreboard side (consumes issue + writeback, drives issue_ready_o)
//   master : dispatch side
interface bp_be_scoreboard_if #(
    parameter int unsigned reg_addr_width_p = 5
) ();
    logic                        issue_v_i;
    logic                        issue_ready_o;
    logic                        issue_irs1_v_i;
    logic                        issue_irs2_v_i;
    logic                        issue_frs1_v_i;
    logic                        issue_frs2_v_i;
    logic [reg_addr_width_p-1:0] issue_rs1_addr_i;
    logic [reg_addr_width_p-1:0] issue_rs2_addr_i;
    logic                        issue_iwb_v_i;
    logic                        issue_fwb_v_i;
    logic [reg_addr_width_p-1:0] issue_rd_addr_i;
    logic                        wb_v_i;
    logic                        wb_fp_i;
    logic [reg_addr_width_p-1:0] wb_rd_addr_i;

    modport slave (
        input  issue_v_i, issue_irs1_v_i, issue_irs2_v_i, issue_frs1_v_i,
               issue_frs2_v_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_iwb_v_i, issue_fwb_v_i, issue_rd_addr_i,
               wb_v_i, wb_fp_i, wb_rd_addr_i,
        output issue_ready_o
    );

    modport master (
        output issue_v_i, issue_irs1_v_i, issue_irs2_v_i, issue_frs1_v_i,
               issue_frs2_v_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_iwb_v_i, issue_fwb_v_i, issue_rd_addr_i,
               wb_v_i, wb_fp_i, wb_rd_addr_i,
        input  issue_ready_o
    );
endinterface

// File: rtl/bp_be_scoreboard_bank.sv
// Outstanding-write counters for one architectural register file.
//   inc_v_i/inc_addr_i  : record a new long-latency write
//   dec_v_i/dec_addr_i  : retire a long-latency write
//   rs1/rs2/rd_addr_i   : lookup indices; *_busy_o = counter nonzero,
//                         rd_full_o = destination counter saturated
//   drain_done_o        : no writes outstanding (see BYPASS note below)
//   err_o               : retire aimed at a zero counter
// zero_reg_masked_p makes register 0 untracked (integer file).
// BP_BE_SCOREBOARD_BYPASS_EN: a retire of a counter at 1 hides that register
// from the lookups this cycle, and drain_done_o looks at post-edge counters.
module bp_be_scoreboard_bank #(
    parameter int unsigned addr_width_p      = 5,
    parameter int unsigned cnt_width_p       = 2,
    parameter bit          zero_reg_masked_p = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    inc_v_i,
    input  logic [addr_width_p-1:0] inc_addr_i,
    input  logic                    dec_v_i,
    input  logic [addr_width_p-1:0] dec_addr_i,
    input  logic [addr_width_p-1:0] rs1_addr_i,
    input  logic [addr_width_p-1:0] rs2_addr_i,
    input  logic [addr_width_p-1:0] rd_addr_i,
    output logic                    rs1_busy_o,
    output logic                    rs2_busy_o,
    output logic                    rd_busy_o,
    output logic                    rd_full_o,
    output logic                    drain_done_o,
    output logic                    err_o
);
    localparam int unsigned num_regs_lp = 1 << addr_width_p;

    typedef logic [addr_width_p-1:0] addr_t;
    typedef logic [cnt_width_p-1:0]  cnt_t;

    cnt_t cnt_q [num_regs_lp];
    cnt_t cnt_d [num_regs_lp];

    logic inc_en, dec_req, dec_en;
    logic byp_rs1, byp_rs2, byp_rd;

    function automatic logic tracked_f(input addr_t a);
        return !(zero_reg_masked_p && (a == '0));
    endfunction

    always_comb begin
        inc_en  = inc_v_i & tracked_f(inc_addr_i);
        dec_req = dec_v_i & tracked_f(dec_addr_i);
        dec_en  = dec_req & (cnt_q[dec_addr_i] != '0);
        err_o   = dec_req & (cnt_q[dec_addr_i] == '0);
        cnt_d   = cnt_q;
        // A colliding increment/retire pair cancels; on a zero counter this
        // also keeps the erroneous retire from letting the increment through.
        if (!(inc_en && dec_req && (inc_addr_i == dec_addr_i))) begin
            if (inc_en) cnt_d[inc_addr_i] = cnt_q[inc_addr_i] + cnt_t'(1);
            if (dec_en) cnt_d[dec_addr_i] = cnt_q[dec_addr_i] - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < num_regs_lp; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef BP_BE_SCOREBOARD_BYPASS_EN
    logic dec_last;
    assign dec_last = dec_en & (cnt_q[dec_addr_i] == cnt_t'(1));
    assign byp_rs1  = dec_last & (dec_addr_i == rs1_addr_i);
    assign byp_rs2  = dec_last & (dec_addr_i == rs2_addr_i);
    assign byp_rd   = dec_last & (dec_addr_i == rd_addr_i);

    always_comb begin
        drain_done_o = 1'b1;
        for (int unsigned i = 0; i < num_regs_lp; i++)
            if (cnt_d[i] != '0) drain_done_o = 1'b0;
    end
`else
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
    assign byp_rd  = 1'b0;

    always_comb begin
        drain_done_o = 1'b1;
        for (int unsigned i = 0; i < num_regs_lp; i++)
            if (cnt_q[i] != '0) drain_done_o = 1'b0;
    end
`endif

    assign rs1_busy_o = (cnt_q[rs1_addr_i] != '0) & tracked_f(rs1_addr_i) & ~byp_rs1;
    assign rs2_busy_o = (cnt_q[rs2_addr_i] != '0) & tracked_f(rs2_addr_i) & ~byp_rs2;
    assign rd_busy_o  = (cnt_q[rd_addr_i]  != '0) & tracked_f(rd_addr_i)  & ~byp_rd;
    assign rd_full_o  = (cnt_q[rd_addr_i]  == '1) & tracked_f(rd_addr_i);

endmodule

// File: rtl/bp_be_scoreboard.sv
// Backend register scoreboard for long-latency int/FP writes.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   sb_if (slave)    : issue handshake + source/destination fields, writeback
//   flush_i          : roll/poison; forces a drain of outstanding writes
//   draining_o       : drain in progress
//   err_o            : sticky protocol error (double destination, stray retire)
// Optional: BP_BE_SCOREBOARD_BYPASS_EN (same-cycle writeback bypass).
module bp_be_scoreboard
    import bp_be_scoreboard_pkg::*;
#(
    parameter int unsigned reg_addr_width_p = sb_reg_addr_width_gp,
    parameter int unsigned cnt_width_p      = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_be_scoreboard_if.slave       sb_if,
    input  logic                    flush_i,
    output logic                    draining_o,
    output logic                    err_o
);
    bp_be_sb_issue_s issue;
    bp_be_sb_wb_s    wb;
    bp_be_sb_state_e state_q, state_d;
    logic            err_q, err_d;
    logic            hazard, ready, xfer, dual_dest;

    logic i_rs1_busy, i_rs2_busy, i_rd_busy, i_rd_full, i_done, i_err;
    logic f_rs1_busy, f_rs2_busy, f_rd_busy, f_rd_full, f_done, f_err;

    assign issue = '{v: sb_if.issue_v_i,
                     irs1_v: sb_if.issue_irs1_v_i, irs2_v: sb_if.issue_irs2_v_i,
                     frs1_v: sb_if.issue_frs1_v_i, frs2_v: sb_if.issue_frs2_v_i,
                     rs1_addr: sb_if.issue_rs1_addr_i, rs2_addr: sb_if.issue_rs2_addr_i,
                     iwb_v: sb_if.issue_iwb_v_i, fwb_v: sb_if.issue_fwb_v_i,
                     rd_addr: sb_if.issue_rd_addr_i};
    assign wb    = '{v: sb_if.wb_v_i, fp: sb_if.wb_fp_i, rd_addr: sb_if.wb_rd_addr_i};

    assign hazard = (issue.irs1_v & i_rs1_busy) | (issue.irs2_v & i_rs2_busy)
                  | (issue.frs1_v & f_rs1_busy) | (issue.frs2_v & f_rs2_busy)
                  | (issue.iwb_v & (i_rd_busy | i_rd_full))
                  | (issue.fwb_v & (f_rd_busy | f_rd_full));

    // Held low through reset so nothing dispatches against stale counters.
    assign ready     = reset_n_i & (state_q == e_sb_run) & ~flush_i & ~hazard;
    assign xfer      = issue.v & ready;
    assign dual_dest = issue.iwb_v & issue.fwb_v;
    assign sb_if.issue_ready_o = ready;

    bp_be_scoreboard_bank #(
        .addr_width_p(reg_addr_width_p), .cnt_width_p(cnt_width_p), .zero_reg_masked_p(1'b1)
    ) int_bank (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .inc_v_i(xfer & issue.iwb_v & ~issue.fwb_v), .inc_addr_i(issue.rd_addr),
        .dec_v_i(wb.v & ~wb.fp), .dec_addr_i(wb.rd_addr),
        .rs1_addr_i(issue.rs1_addr), .rs2_addr_i(issue.rs2_addr), .rd_addr_i(issue.rd_addr),
        .rs1_busy_o(i_rs1_busy), .rs2_busy_o(i_rs2_busy), .rd_busy_o(i_rd_busy),
        .rd_full_o(i_rd_full), .drain_done_o(i_done), .err_o(i_err)
    );

    bp_be_scoreboard_bank #(
        .addr_width_p(reg_addr_width_p), .cnt_width_p(cnt_width_p), .zero_reg_masked_p(1'b0)
    ) fp_bank (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .inc_v_i(xfer & issue.fwb_v & ~issue.iwb_v), .inc_addr_i(issue.rd_addr),
        .dec_v_i(wb.v & wb.fp), .dec_addr_i(wb.rd_addr),
        .rs1_addr_i(issue.rs1_addr), .rs2_addr_i(issue.rs2_addr), .rd_addr_i(issue.rd_addr),
        .rs1_busy_o(f_rs1_busy), .rs2_busy_o(f_rs2_busy), .rd_busy_o(f_rd_busy),
        .rd_full_o(f_rd_full), .drain_done_o(f_done), .err_o(f_err)
    );

    always_comb begin
        state_d    = state_q;
        draining_o = 1'b0;
        err_d      = err_q | (xfer & dual_dest) | i_err | f_err;
        case (state_q)
            e_sb_run: begin
                if (flush_i) state_d = e_sb_drain;
            end
            e_sb_drain: begin
                draining_o = 1'b1;
                if (!flush_i && i_done && f_done) state_d = e_sb_run;
            end
            default: state_d = e_sb_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_sb_run;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_bp_be_scoreboard.sv
// Self-checking bench for bp_be_scoreboard: directed vector table, hand-built
// reset/error sequences, then randomized traffic against a counter-array model.
module tb_bp_be_scoreboard;

`ifdef BP_BE_SCOREBOARD_BYPASS_EN
    localparam bit byp = 1'b1;
`else
    localparam bit byp = 1'b0;
`endif
    localparam int max_cnt = 3;

    typedef struct {
        bit iv, irs1, irs2, frs1, frs2;
        bit [4:0] rs1, rs2;
        bit iwb, fwb;
        bit [4:0] rd;
        bit wbv, wbfp;
        bit [4:0] wbrd;
        bit fl;
        bit er, ed, ee;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush, draining, err;
    int   n_vec = 0;
    int   n_miss = 0;

    bp_be_scoreboard_if #(.reg_addr_width_p(5)) sb_if ();

    bp_be_scoreboard #(.reg_addr_width_p(5), .cnt_width_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .sb_if(sb_if),
        .flush_i(flush), .draining_o(draining), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding-write count per register, drain flag, error.
    int   cnt [2][32];
    bit   m_drain, m_err;
    vec_t cur;

    function automatic vec_t mkv(bit iv, bit [3:0] src, int rs1, int rs2, bit iwb, bit fwb,
                                 int rd, bit wbv, bit wbfp, int wbrd, bit fl,
                                 bit er, bit ed, bit ee);
        vec_t v;
        v.iv = iv; v.irs1 = src[3]; v.irs2 = src[2]; v.frs1 = src[1]; v.frs2 = src[0];
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.iwb = iwb; v.fwb = fwb; v.rd = 5'(rd);
        v.wbv = wbv; v.wbfp = wbfp; v.wbrd = 5'(wbrd); v.fl = fl;
        v.er = er; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    function automatic vec_t idle(bit er, bit ed, bit ee);
        return mkv(0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, ed, ee);
    endfunction

    task automatic model_reset();
        foreach (cnt[f, r]) cnt[f][r] = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic bit m_busy(int fp, int a);
        int c = cnt[fp][a];
        if (fp == 0 && a == 0) return 1'b0;
        if (byp && cur.wbv && int'(cur.wbfp) == fp && int'(cur.wbrd) == a && c == 1) return 1'b0;
        return c > 0;
    endfunction

    function automatic bit m_ready();
        bit hz;
        if (m_drain || cur.fl) return 1'b0;
        hz = (cur.irs1 && m_busy(0, cur.rs1)) || (cur.irs2 && m_busy(0, cur.rs2))
          || (cur.frs1 && m_busy(1, cur.rs1)) || (cur.frs2 && m_busy(1, cur.rs2))
          || (cur.iwb && (m_busy(0, cur.rd) || cnt[0][cur.rd] >= max_cnt))
          || (cur.fwb && (m_busy(1, cur.rd) || cnt[1][cur.rd] >= max_cnt));
        return !hz;
    endfunction

    function automatic bit m_all_zero();
        foreach (cnt[f, r]) if (cnt[f][r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update();
        bit xfer, inc, dec, pre_zero, post_zero;
        int ifp, dfp;
        xfer     = cur.iv && m_ready();
        pre_zero = m_all_zero();
        ifp      = cur.fwb ? 1 : 0;
        dfp      = cur.wbfp ? 1 : 0;
        inc      = xfer && (cur.iwb != cur.fwb) && !(cur.iwb && cur.rd == 0);
        dec      = cur.wbv && !(!cur.wbfp && cur.wbrd == 0);
        if (xfer && cur.iwb && cur.fwb) m_err = 1'b1;
        if (dec && cnt[dfp][cur.wbrd] == 0) m_err = 1'b1;
        if (!(inc && dec && ifp == dfp && cur.rd == cur.wbrd)) begin
            if (inc) cnt[ifp][cur.rd]++;
            if (dec && cnt[dfp][cur.wbrd] > 0) cnt[dfp][cur.wbrd]--;
        end
        post_zero = m_all_zero();
        if (!m_drain) m_drain = cur.fl;
        else if (!cur.fl && (byp ? post_zero : pre_zero)) m_drain = 1'b0;
    endtask

    task automatic chk(input string tag, input string what, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %b expected %b", tag, what, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cur = v;
        sb_if.issue_v_i        = v.iv;
        sb_if.issue_irs1_v_i   = v.irs1;
        sb_if.issue_irs2_v_i   = v.irs2;
        sb_if.issue_frs1_v_i   = v.frs1;
        sb_if.issue_frs2_v_i   = v.frs2;
        sb_if.issue_rs1_addr_i = v.rs1;
        sb_if.issue_rs2_addr_i = v.rs2;
        sb_if.issue_iwb_v_i    = v.iwb;
        sb_if.issue_fwb_v_i    = v.fwb;
        sb_if.issue_rd_addr_i  = v.rd;
        sb_if.wb_v_i           = v.wbv;
        sb_if.wb_fp_i          = v.wbfp;
        sb_if.wb_rd_addr_i     = v.wbrd;
        flush                  = v.fl;
    endtask

    // One cycle: drive at posedge+1, compare mid-cycle, advance model on the edge.
    task automatic step(input vec_t v, input bit use_model, input string tag);
        drive(v);
        #3;
        if (use_model) begin
            chk(tag, "ready", sb_if.issue_ready_o, m_ready());
            chk(tag, "draining", draining, m_drain);
            chk(tag, "err", err, m_err);
        end else begin
            chk(tag, "ready", sb_if.issue_ready_o, v.er);
            chk(tag, "draining", draining, v.ed);
            chk(tag, "err", err, v.ee);
        end
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(idle(0, 0, 0));
        model_reset();
        @(posedge clk);
        #3;
        chk("reset", "ready", sb_if.issue_ready_o, 1'b0);
        chk("reset", "draining", draining, 1'b0);
        chk("reset", "err", err, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t gen_rand();
        vec_t v;
        int   d, wf, wa;
        v = idle(0, 0, 0);
        v.iv   = $urandom_range(0, 9) < 7;
        v.irs1 = 1'($urandom_range(0, 1));
        v.irs2 = 1'($urandom_range(0, 1));
        v.frs1 = 1'($urandom_range(0, 1));
        v.frs2 = 1'($urandom_range(0, 1));
        v.rs1  = 5'($urandom_range(0, 7));
        v.rs2  = 5'($urandom_range(0, 7));
        v.rd   = 5'($urandom_range(0, 7));
        d = $urandom_range(0, 29);
        v.iwb  = (d == 0) || (d < 12);
        v.fwb  = (d == 0) || (d >= 12 && d < 22);
        wf = $urandom_range(0, 1);
        wa = $urandom_range(0, 7);
        v.wbfp = 1'(wf);
        v.wbrd = 5'(wa);
        v.wbv  = (cnt[wf][wa] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
        v.fl   = $urandom_range(0, 39) == 0;
        return v;
    endfunction

    vec_t tab[$];

    initial begin
        // Directed table; expectations are the outputs seen during that cycle.
        tab.push_back(idle(1, 0, 0));
        tab.push_back(mkv(1, 4'b0000, 0, 0, 1, 0, 5,  0, 0, 0, 0,  1, 0, 0));   // x5 outstanding
        tab.push_back(mkv(1, 4'b1000, 5, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));   // RAW x5
        tab.push_back(mkv(1, 4'b1000, 5, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tab.push_back(mkv(1, 4'b1000, 5, 0, 0, 0, 0,  1, 0, 5, 0,  byp, 0, 0)); // wb x5
        tab.push_back(mkv(1, 4'b1000, 5, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0));
        tab.push_back(mkv(1, 4'b1000, 0, 0, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0));   // write x0
        tab.push_back(mkv(1, 4'b1100, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0));   // read x0
        tab.push_back(mkv(1, 4'b0010, 7, 0, 0, 1, 7,  0, 0, 0, 0,  1, 0, 0));   // f7 outstanding
        tab.push_back(mkv(1, 4'b0000, 0, 0, 0, 1, 7,  0, 0, 0, 0,  0, 0, 0));   // WAW f7
        tab.push_back(mkv(1, 4'b0001, 0, 7, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));   // RAW f7
        tab.push_back(mkv(1, 4'b1000, 7, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0));   // x7 is separate
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 1, 7, 0,  1, 0, 0));   // wb f7
        tab.push_back(mkv(1, 4'b0000, 0, 0, 0, 1, 7,  0, 0, 0, 0,  1, 0, 0));   // f7 again
        tab.push_back(mkv(1, 4'b0000, 0, 0, 1, 0, 3,  0, 0, 0, 0,  1, 0, 0));   // x3
        tab.push_back(mkv(1, 4'b0000, 0, 0, 0, 1, 9,  0, 0, 0, 0,  1, 0, 0));   // f9
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 1, 7, 0,  1, 0, 0));   // wb f7
        tab.push_back(mkv(1, 4'b1000, 20, 0, 1, 0, 20, 0, 0, 0, 1, 0, 0, 0));   // flush beats issue
        tab.push_back(idle(0, 1, 0));
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 3, 0,  0, 1, 0));   // wb x3
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 1, 9, 0,  0, 1, 0));   // wb f9
        tab.push_back(idle(byp, !byp, 0));
        tab.push_back(idle(1, 0, 0));
        tab.push_back(mkv(1, 4'b1000, 20, 0, 1, 0, 20, 0, 0, 0, 0, 1, 0, 0));   // x20 was not recorded
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 20, 0, 1, 0, 0));
        tab.push_back(idle(0, 0, 0)); tab[$].fl = 1'b1;                          // empty drain
        tab.push_back(idle(0, 1, 0));
        tab.push_back(idle(1, 0, 0));
        tab.push_back(idle(0, 0, 0)); tab[$].fl = 1'b1;                          // flush held in drain
        tab.push_back(idle(0, 1, 0)); tab[$].fl = 1'b1;
        tab.push_back(idle(0, 1, 0));
        tab.push_back(idle(1, 0, 0));
        tab.push_back(mkv(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 12, 0, 1, 0, 0));   // stray wb x12
        tab.push_back(idle(1, 0, 1));
        tab.push_back(mkv(1, 4'b1000, 12, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1));   // x12 stays 0
        tab.push_back(idle(1, 0, 1));

        do_reset();
        for (int i = 0; i < tab.size(); i++) step(tab[i], 1'b0, $sformatf("tab%0d", i));

        // Asynchronous reset in the middle of a drain with x4 outstanding.
        step(mkv(1, 4'b0000, 0, 0, 1, 0, 4, 0, 0, 0, 0, 1, 0, 1), 1'b0, "ar_issue");
        step(idle(1, 0, 1), 1'b0, "ar_pre");
        cur = idle(0, 0, 0); cur.fl = 1'b1;
        drive(cur);
        @(posedge clk);
        #1;
        drive(idle(0, 0, 0));
        #2;
        chk("ar_before", "draining", draining, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("ar_during", "draining", draining, 1'b0);
        chk("ar_during", "ready", sb_if.issue_ready_o, 1'b0);
        chk("ar_during", "err", err, 1'b0);
        model_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(mkv(1, 4'b1000, 4, 0, 1, 0, 4, 0, 0, 0, 0, 1, 0, 0), 1'b0, "ar_x4_free");
        step(mkv(1, 4'b1000, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "ar_x4_raw");

        // Both destination kinds at once: flagged and not recorded.
        step(mkv(1, 4'b0000, 0, 0, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0), 1'b0, "dual");
        step(idle(1, 0, 1), 1'b0, "dual_err");
        step(mkv(1, 4'b1001, 6, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 1'b0, "dual_norec");

        do_reset();
        for (int i = 0; i < 2000; i++) step(gen_rand(), 1'b1, $sformatf("rnd%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
